ntt_coeff_unloader: RTL and testbench
=====================================

Name: ntt_coeff_unloader

Overview:
- Output stage downstream of the NTT datapath. On a `start` pulse it reads all `RING_SIZE` coefficients from the two half-size coefficient RAM banks in natural index order.
- Bank 1 holds indices 0..N/2-1 and bank 2 holds N/2..N-1, the same split the bit-reversal loader uses when writing.
- It streams the coefficients out on a valid/ready interface and pulses `done` when the last one is accepted.
- A 2-entry skid buffer absorbs the 1-cycle RAM read latency, so downstream backpressure never drops or duplicates data.

Parameters:
- DATA_W, default `DATA_SIZE_ARB: coefficient width.
- N, default `RING_SIZE: coefficients per polynomial. Must be a power of 2, ≥ 4.
- LOG_N, default $clog2(N): index and address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin unloading; honoured only in IDLE
- ram1_re  out  1  read enable, bank 1
- ram2_re  out  1  read enable, bank 2
- addr  out  LOG_N  bank-local read address; MSB always 0
- ram1_dout  in  DATA_W  bank 1 read data, valid 1 cycle after ram1_re
- ram2_dout  in  DATA_W  bank 2 read data, valid 1 cycle after ram2_re
- dout  out  DATA_W  coefficient out
- dout_valid  out  1  dout holds a coefficient
- dout_ready  in  1  consumer accepts; a transfer occurs when valid && ready
- dout_last  out  1  qualifies dout as index N-1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last transfer

Behaviour:
- Reset: state IDLE, idx=0, buffer empty, in-flight flag clear. All outputs are 0 in the cycle after reset is sampled, including dout.
- States:
  - IDLE: start=1 → READ.
  - READ: issues reads. After issuing idx=N-1 → DRAIN.
  - DRAIN: waits until no read is in flight and the buffer is empty → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
- Read issue (READ state only): a read is issued in a cycle iff `occ + inflight - pop < 2`, where pop = dout_valid && dout_ready in that cycle.
  - Issue cycle, idx < N/2: ram1_re=1, addr=idx.
  - Issue cycle, idx ≥ N/2: ram2_re=1, addr=idx-N/2.
  - idx increments on each issue.
  - ram1_re and ram2_re are never high together. addr=0 in any cycle with no read.
- Capture: the bank select and the last flag (idx==N-1) are registered alongside inflight. In the next cycle the selected ram*_dout is written into the buffer with its last flag.
- Buffer: 2-entry FIFO, with simultaneous push and pop allowed. dout/dout_valid/dout_last come from the head entry.
  - While valid && !ready, dout and dout_last hold stable.
  - Overflow is impossible by the credit rule. The bench asserts this.
- Latency: start sampled at edge e0. The first read issues in the cycle after e0, and dout_valid first rises 3 cycles after e0. With dout_ready held at 1, one coefficient transfers per cycle with no bubbles.
- done: asserted the cycle after the transfer with dout_last=1. busy falls together with done's deassertion.
- start while busy: ignored, with no effect on idx or state.
- reset mid-operation: immediate abort. The buffer and in-flight data are discarded, done never pulses, and the next start restarts from idx 0.
- Width rules: idx is a LOG_N+1 bit counter so it can test reaching N without wrapping. addr is truncated to LOG_N bits.

Decomposition:
- Package ntt_pkg:
  - DATA_W, N, LOG_N, HALF_N constants derived from `DATA_SIZE_ARB/`RING_SIZE.
  - Typedef coeff_t [DATA_W-1:0].
  - Typedef idx_t [LOG_N:0].
  - Enum unload_state_t {IDLE, READ, DRAIN, DONE}.
- Sub-module ntt_skid_fifo: 2-entry FIFO of {last, coeff}, with push, pop, occ[1:0], and head outputs. It is reusable by the butterfly stage.

Test Plan:
- N=8, bank1={10,11,12,13}, bank2={14,15,16,17}, dout_ready=1, start pulse → ram1_re on 4 consecutive cycles with addr 0..3, then ram2_re with addr 0..3. dout=10..17 on 8 consecutive cycles starting 3 cycles after start. dout_last only with 17. done the cycle after, then busy=0.
- Same preload, dout_ready alternating 1/0 → output sequence exactly 10..17 with no loss or duplicate. dout stable during every stall. Buffer occupancy ≤2 throughout.
- dout_ready=0 for 10 cycles after start → exactly 2 reads issued (addr 0, 1 on bank 1), dout=10 held valid. Releasing ready resumes with 11..17 and then done.
- start pulsed again during READ, and again at DONE → both ignored. A start after return to IDLE reproduces 10..17 and a second done.
- reset asserted in the cycle 12 transfers → next cycle all outputs 0, no done pulse. A fresh start then yields 10..17 from the beginning.

Source files
------------

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared widths, index types and unloader states for the NTT output path.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 16
`endif
`ifndef RING_SIZE
`define RING_SIZE 8
`endif
package ntt_pkg;
    localparam int DATA_W = `DATA_SIZE_ARB;
    localparam int N      = `RING_SIZE;
    localparam int LOG_N  = $clog2(N);
    localparam int HALF_N = N / 2;
    typedef logic [DATA_W-1:0] coeff_t;
    typedef logic [LOG_N:0] idx_t;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} unload_state_t;
endpackage

// File: rtl/ntt_skid_fifo.sv
// ntt_skid_fifo: 2-entry FIFO with simultaneous push/pop; head is the oldest entry.
module ntt_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);
    logic [W-1:0] tail;

    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push && (occ == 2'd0 || (occ == 2'd1 && pop))) head <= din;
            else if (pop) head <= tail;
            if (push && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop))) tail <= din;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/ntt_coeff_unloader.sv
// ntt_coeff_unloader: streams N coefficients from two half-size RAM banks in natural
// order over valid/ready; a skid FIFO absorbs the 1-cycle RAM read latency.
module ntt_coeff_unloader #(
    parameter int DATA_W = ntt_pkg::DATA_W,
    parameter int N      = ntt_pkg::N,
    parameter int LOG_N  = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              ram1_re,
    output logic              ram2_re,
    output logic [LOG_N-1:0]  addr,
    input  logic [DATA_W-1:0] ram1_dout,
    input  logic [DATA_W-1:0] ram2_dout,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              busy,
    output logic              done
);
    import ntt_pkg::*;

    localparam logic [LOG_N:0] LAST_IDX = (LOG_N+1)'(N - 1);

    unload_state_t   state, state_nx;
    logic [LOG_N:0]  idx;
    logic            inflight, infl_hi, infl_last, issue, pop;
    logic [1:0]      occ;
    logic [2:0]      credit;
    logic [DATA_W:0] head;

    assign dout_valid = occ != 2'd0;
    assign pop        = dout_valid && dout_ready;
    assign {dout_last, dout} = head;
    // FIFO slots already spoken for, net of this cycle's pop; keeps pushes from overflowing
    assign credit  = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign issue   = state == READ && credit < 3'd2;
    assign ram1_re = issue && !idx[LOG_N-1];
    assign ram2_re = issue && idx[LOG_N-1];
    assign addr    = issue ? {1'b0, idx[LOG_N-2:0]} : '0;
    assign busy    = state != IDLE;
    assign done    = state == DONE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? READ : IDLE;
            READ:    state_nx = (issue && idx == LAST_IDX) ? DRAIN : READ;
            DRAIN:   state_nx = (!inflight && occ == {1'b0, pop}) ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            inflight  <= 1'b0;
            infl_hi   <= 1'b0;
            infl_last <= 1'b0;
        end else begin
            state     <= state_nx;
            inflight  <= issue;
            infl_hi   <= idx[LOG_N-1];
            infl_last <= idx == LAST_IDX;
            if (state == IDLE && start) idx <= '0;
            else if (issue) idx <= idx + 1'b1;
        end
    end

    ntt_skid_fifo #(.W(DATA_W + 1)) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (inflight),
        .din  ({infl_last, infl_hi ? ram2_dout : ram1_dout}),
        .pop  (pop),
        .occ  (occ),
        .head (head)
    );
endmodule

// File: tb/tb_ntt_coeff_unloader.sv
// tb_ntt_coeff_unloader: randomized scenarios against a natural-order scoreboard
// with a behavioural two-bank RAM model.
module tb_ntt_coeff_unloader;
    localparam int DW = 16;
    localparam int N  = 8;
    localparam int LN = 3;
    localparam int H  = N / 2;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, dout_ready = 1'b0;
    logic ram1_re, ram2_re, dout_valid, dout_last, busy, done;
    logic [LN-1:0] addr;
    logic [DW-1:0] ram1_dout, ram2_dout, dout;
    logic [DW-1:0] bank1 [H];
    logic [DW-1:0] bank2 [H];
    logic [DW-1:0] exp_seq [N];
    logic [DW:0] out_q [$];
    logic [LN:0] reads [$];
    logic prev_stall = 1'b0;
    logic [DW:0] prev_v = '0;
    int checks = 0, errors = 0;
    int stall_bad = 0, proto_bad = 0, occ_bad = 0, done_cnt = 0;

    ntt_coeff_unloader #(.DATA_W(DW), .N(N)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ram1_re(ram1_re), .ram2_re(ram2_re), .addr(addr),
        .ram1_dout(ram1_dout), .ram2_dout(ram2_dout),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_last(dout_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // RAM banks: registered read, data valid one cycle after the enable
    always @(posedge clk) begin
        if (ram1_re) ram1_dout <= bank1[addr[LN-2:0]];
        if (ram2_re) ram2_dout <= bank2[addr[LN-2:0]];
    end

    // Monitor: records transfers and reads, tallies protocol violations
    always @(negedge clk) begin
        if (prev_stall && (!dout_valid || {dout_last, dout} !== prev_v)) stall_bad++;
        prev_stall = dout_valid === 1'b1 && dout_ready === 1'b0 && !reset;
        prev_v = {dout_last, dout};
        if (dout_valid === 1'b1 && dout_ready === 1'b1) out_q.push_back({dout_last, dout});
        if ((ram1_re && ram2_re) || addr[LN-1] === 1'b1 || (!ram1_re && !ram2_re && addr !== '0)) proto_bad++;
        if (ram1_re === 1'b1 || ram2_re === 1'b1) reads.push_back({ram2_re, addr});
        if (dut.u_fifo.occ === 2'd3) occ_bad++;
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_banks(input bit fixed);
        for (int i = 0; i < N; i++) begin
            exp_seq[i] = fixed ? DW'(10 + i) : DW'($urandom);
            if (i < H) bank1[i] = exp_seq[i];
            else bank2[i-H] = exp_seq[i];
        end
    endtask

    // mode 0: ready held high, 1: alternating, 2: random; extra pulses start mid-run and at DONE
    task automatic run_op(input int mode, input bit extra, output bit to);
        start = 1'b1;
        tick();
        start = 1'b0;
        to = 1'b1;
        for (int c = 1; c < 200; c++) begin
            dout_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(c % 2) : ($urandom_range(0, 2) != 0);
            start = extra && c == 3;
            if (done === 1'b1) begin
                to = 1'b0;
                start = extra;
                break;
            end
            tick();
        end
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({ram1_re, ram2_re, addr, dout_valid, dout_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0", {ram1_re, ram2_re, addr, dout_valid, dout_last, busy, done});
        end
        checks++;
        if (dout !== '0) begin
            errors++;
            $display("FAIL reset_dout: got %h want 0", dout);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        int dc;
        new_banks(1'b1);
        dc = done_cnt;
        dout_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            logic er1, er2, ev, el, ed, eb;
            logic [LN-1:0] ea;
            er1 = c <= 4;
            er2 = c >= 5 && c <= 8;
            ea  = (er1 || er2) ? LN'((c - 1) % H) : '0;
            ev  = c >= 3 && c <= 10;
            el  = c == 10;
            ed  = c == 11;
            eb  = c <= 11;
            checks++;
            if ({ram1_re, ram2_re, addr, dout_valid, dout_last, done, busy} !== {er1, er2, ea, ev, el, ed, eb}) begin
                errors++;
                $display("FAIL stream_ctrl c=%0d: got %b want %b", c,
                         {ram1_re, ram2_re, addr, dout_valid, dout_last, done, busy}, {er1, er2, ea, ev, el, ed, eb});
            end
            if (ev) begin
                checks++;
                if (dout !== DW'(10 + c - 3)) begin
                    errors++;
                    $display("FAIL stream_dout c=%0d: got %0d want %0d", c, dout, 10 + c - 3);
                end
            end
            tick();
        end
        checks++;
        if (done_cnt != dc + 1) begin
            errors++;
            $display("FAIL stream_done_count: got %0d want %0d", done_cnt - dc, 1);
        end
    endtask

    task automatic test_backpressure(input int mode, input int runs);
        for (int r = 0; r < runs; r++) begin
            int b, sb, pb, dc;
            bit to;
            new_banks(1'b0);
            b = out_q.size(); sb = stall_bad; pb = proto_bad; dc = done_cnt;
            run_op(mode, 1'b0, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL bp_timeout mode=%0d: got no done want done", mode);
            end
            checks++;
            if (out_q.size() - b != N) begin
                errors++;
                $display("FAIL bp_count mode=%0d: got %0d want %0d", mode, out_q.size() - b, N);
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (out_q[b+i] !== {i == N - 1, exp_seq[i]}) begin
                    errors++;
                    $display("FAIL bp_data mode=%0d i=%0d: got %h want %h", mode, i, out_q[b+i], {i == N - 1, exp_seq[i]});
                end
            end
            checks++;
            if (stall_bad != sb || proto_bad != pb || occ_bad != 0 || done_cnt != dc + 1) begin
                errors++;
                $display("FAIL bp_protocol mode=%0d: got stall=%0d proto=%0d occ=%0d done=%0d want 0 0 0 1",
                         mode, stall_bad - sb, proto_bad - pb, occ_bad, done_cnt - dc);
            end
        end
    endtask

    task automatic test_stall10();
        int b, rb, sb, dc;
        bit to;
        new_banks(1'b0);
        b = out_q.size(); rb = reads.size(); sb = stall_bad; dc = done_cnt;
        dout_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        checks++;
        if (reads.size() - rb != 2 || {reads[rb], reads[rb+1]} !== {1'b0, 3'd0, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL stall_reads: got n=%0d first=%h,%h want n=2 0,1", reads.size() - rb, reads[rb], reads[rb+1]);
        end
        checks++;
        if ({dout_valid, dout} !== {1'b1, exp_seq[0]} || out_q.size() != b) begin
            errors++;
            $display("FAIL stall_head: got v=%b d=%h xfers=%0d want v=1 d=%h xfers=0", dout_valid, dout, out_q.size() - b, exp_seq[0]);
        end
        dout_ready = 1'b1;
        to = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (done === 1'b1) begin
                to = 1'b0;
                break;
            end
            tick();
        end
        tick();
        checks++;
        if (to || out_q.size() - b != N || stall_bad != sb || done_cnt != dc + 1) begin
            errors++;
            $display("FAIL stall_resume: got timeout=%0d xfers=%0d stall=%0d done=%0d want 0 %0d 0 1",
                     to, out_q.size() - b, stall_bad - sb, done_cnt - dc, N);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (out_q[b+i] !== {i == N - 1, exp_seq[i]}) begin
                errors++;
                $display("FAIL stall_data i=%0d: got %h want %h", i, out_q[b+i], {i == N - 1, exp_seq[i]});
            end
        end
    endtask

    task automatic test_start_ignored();
        int b, dc;
        bit to;
        new_banks(1'b0);
        b = out_q.size(); dc = done_cnt;
        run_op(0, 1'b1, to);
        checks++;
        if (busy !== 1'b0 || ram1_re !== 1'b0) begin
            errors++;
            $display("FAIL ign_idle: got busy=%b re=%b want 0 0", busy, ram1_re);
        end
        repeat (3) tick();
        checks++;
        if (to || busy !== 1'b0 || out_q.size() - b != N || done_cnt != dc + 1) begin
            errors++;
            $display("FAIL ign_first: got timeout=%0d busy=%b xfers=%0d done=%0d want 0 0 %0d 1",
                     to, busy, out_q.size() - b, done_cnt - dc, N);
        end
        run_op(0, 1'b0, to);
        checks++;
        if (to || out_q.size() - b != 2 * N || done_cnt != dc + 2) begin
            errors++;
            $display("FAIL ign_second: got timeout=%0d xfers=%0d done=%0d want 0 %0d 2", to, out_q.size() - b, done_cnt - dc, 2 * N);
        end
        for (int i = 0; i < 2 * N; i++) begin
            checks++;
            if (out_q[b+i] !== {i % N == N - 1, exp_seq[i % N]}) begin
                errors++;
                $display("FAIL ign_data i=%0d: got %h want %h", i, out_q[b+i], {i % N == N - 1, exp_seq[i % N]});
            end
        end
    endtask

    task automatic test_reset_mid();
        int b, dc;
        bit to;
        new_banks(1'b0);
        b = out_q.size(); dc = done_cnt;
        dout_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({ram1_re, ram2_re, addr, dout, dout_valid, dout_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %h want 0", {ram1_re, ram2_re, addr, dout, dout_valid, dout_last, busy, done});
        end
        reset = 1'b0;
        repeat (8) tick();
        checks++;
        if (done_cnt != dc || busy !== 1'b0 || out_q.size() - b != 2) begin
            errors++;
            $display("FAIL rstmid_abort: got done=%0d busy=%b xfers=%0d want 0 0 2", done_cnt - dc, busy, out_q.size() - b);
        end
        b = out_q.size();
        run_op(0, 1'b0, to);
        checks++;
        if (to || out_q.size() - b != N || done_cnt != dc + 1) begin
            errors++;
            $display("FAIL rstmid_restart: got timeout=%0d xfers=%0d done=%0d want 0 %0d 1", to, out_q.size() - b, done_cnt - dc, N);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (out_q[b+i] !== {i == N - 1, exp_seq[i]}) begin
                errors++;
                $display("FAIL rstmid_data i=%0d: got %h want %h", i, out_q[b+i], {i == N - 1, exp_seq[i]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure(1, 1);
        test_stall10();
        test_start_ignored();
        test_reset_mid();
        test_backpressure(2, 4);
        test_backpressure(0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
